md_unit_ctrl: RTL and testbench
===============================

// Module: md_unit_ctrl
// PURPOSE
//  Multiply/divide sequencer for the 5-stage pipeline; sits beside the E-stage ALU.
//  Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E and owns the HI/LO registers.
//  Holds busy for a fixed latency, then commits the result.
//  Produces the stall request that the D-stage hazard logic ORs into its stall.
// PARAMETERS
//  MULT_CYC  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYC   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk       in   1   single clock, rising edge
//  reset     in   1   asynchronous, active-low reset
//  start     in   1   E-stage md instruction valid this cycle
//  op        in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 ignored
//  rs_val    in   32  forwarded rs operand from E
//  rt_val    in   32  forwarded rt operand from E
//  flush     in   1   E instruction cancelled (exception/interrupt); gates start
//  md_use_D  in   1   D-stage instr is md-class (mult/div/mt*/mf*)
//  busy      out  1   operation in flight
//  stall_md  out  1   stall request to D stage
//  hi        out  32  HI register (read by MFHI in E)
//  lo        out  32  LO register (read by MFLO in E)
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE, cnt=0, hi=lo=0, busy=0, pending results cleared.
//    Any in-flight op is abandoned with no commit.
//  - accept = start & ~flush & (state==IDLE). Start while busy is ignored and flagged by an assertion.
//    D-stall guarantees this never happens in a correct pipeline.
//  - States: IDLE, MUL, DIV.
//    IDLE -> MUL on an accepted op 0/1. IDLE -> DIV on an accepted op 2/3.
//    MUL/DIV -> IDLE when cnt==1.
//  - On an accepted mult/div edge: the result is computed from rs/rt and latched into pend_hi/pend_lo.
//    cnt is loaded with MULT_CYC or DIV_CYC.
//  - busy = (state!=IDLE). It is high for exactly N cycles after the accept edge.
//  - Commit: at the edge where cnt==1, {hi,lo}<={pend_hi,pend_lo}, cnt->0, state->IDLE.
//    Result is visible and busy is low in the same cycle after that edge.
//  - MTHI/MTLO: accepted only when IDLE; write hi/lo (resp.) <= rs_val at that edge.
//    Zero latency, state unchanged, busy stays low.
//  - MULT: signed 64-bit product, hi=[63:32], lo=[31:0]. MULTU: unsigned product.
//  - DIV: lo=quotient truncated toward 0; hi=remainder, sign follows the dividend.
//    0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. DIVU is unsigned.
//  - Divide by zero (rt_val==0): full DIV_CYC busy, then commit is skipped; hi/lo keep prior values.
//  - stall_md = md_use_D & (busy | (start & ~flush & op<=3)). It is combinational.
//  - flush with start on the same cycle: nothing accepted, no state change.
//    flush during busy has no effect; the committed op completes.
//  - Ops 6-7: no effect.
// TESTING
//  1. MULT rs=0xFFFFFFFD rt=5 -> busy high 5 cycles; then hi=0xFFFFFFFF lo=0xFFFFFFF1.
//  2. DIVU rs=7 rt=2 -> busy 10 cycles, then lo=3 hi=1.
//     DIV rs=-7 rt=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
//  3. MTHI 0x1234 then DIV rs=5 rt=0 -> busy 10 cycles; hi stays 0x1234, lo unchanged.
//  4. MULTU 0xFFFFFFFF*0xFFFFFFFF with md_use_D=1 during busy -> stall_md=1 for all 5 busy cycles.
//     stall_md drops on the commit cycle; hi=0xFFFFFFFE lo=1.
//  5. Drive reset low at cycle 3 of a DIV -> busy=0, hi=lo=0 immediately.
//     After release, a new MULT 2*3 gives lo=6.
//  6. start=1 flush=1 op=MULT -> busy stays 0, hi/lo unchanged. Start asserted while busy -> ignored.

Source files
------------

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer beside the E-stage ALU; owns HI/LO.
// Ports: clk, reset(n), start/op/rs_val/rt_val/flush from E, md_use_D from D; busy, stall_md, hi, lo.
module md_unit_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CMAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          pend_dz;

  logic accept;
  logic is_mul;
  logic is_div;
  logic is_mthi;
  logic is_mtlo;

  assign accept  = start & ~flush & (state == S_IDLE);
  assign is_mul  = (op == 3'd0) | (op == 3'd1);
  assign is_div  = (op == 3'd2) | (op == 3'd3);
  assign is_mthi = (op == 3'd4);
  assign is_mtlo = (op == 3'd5);

  assign stall_md = md_use_D &
    (busy | (start & ~flush & (op <= 3'd3)));

  // Sign/zero extension to 64 bits makes one
  // unsigned multiplier serve MULT and MULTU.
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;

  always_comb begin
    mul_a = {32'd0, rs_val};
    mul_b = {32'd0, rt_val};
    if (op == 3'd0) begin
      mul_a = {{32{rs_val[31]}}, rs_val};
      mul_b = {{32{rt_val[31]}}, rt_val};
    end
    prod = mul_a * mul_b;
  end

  // Signed divide via magnitudes so that
  // 0x80000000 / -1 wraps to 0x80000000, rem 0.
  logic        a_neg;
  logic        b_neg;
  logic [31:0] ua;
  logic [31:0] ub;
  logic [31:0] ub_safe;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        dz;

  always_comb begin
    a_neg   = ~op[0] & rs_val[31];
    b_neg   = ~op[0] & rt_val[31];
    ua      = a_neg ? -rs_val : rs_val;
    ub      = b_neg ? -rt_val : rt_val;
    dz      = (rt_val == 32'd0);
    ub_safe = dz ? 32'd1 : ub;
    uq      = ua / ub_safe;
    ur      = ua % ub_safe;
    quo     = (a_neg ^ b_neg) ? -uq : uq;
    rem     = a_neg ? -ur : ur;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_dz <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            unique case (1'b1)
              is_mul: begin
                state   <= S_MUL;
                busy    <= 1'b1;
                cnt     <= CW'(MULT_CYC);
                pend_hi <= prod[63:32];
                pend_lo <= prod[31:0];
                pend_dz <= 1'b0;
              end
              is_div: begin
                state   <= S_DIV;
                busy    <= 1'b1;
                cnt     <= CW'(DIV_CYC);
                pend_hi <= rem;
                pend_lo <= quo;
                pend_dz <= dz;
              end
              is_mthi: hi <= rs_val;
              is_mtlo: lo <= rs_val;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          if (cnt == CW'(1)) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            // A zero divisor still burns the full
            // latency but leaves HI/LO untouched.
            if (!pend_dz) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // An md instruction flagged in D last cycle
  // must have been held there while busy.
  a_no_start_busy: assert property (
    @(posedge clk) disable iff (!reset)
    (start && !flush && busy && op <= 3'd5)
      |-> !$past(md_use_D)
  );

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl.
// Checks latency, HI/LO results, stall, flush and reset.
module tb_md_unit_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        md_use_D;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk = 0;
  int n_err = 0;
  int n;

  md_unit_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .flush    (flush),
    .md_use_D (md_use_D),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count busy cycles after the accept edge,
  // optionally checking stall_md each cycle.
  task automatic wait_idle(
    input  bit want_stall,
    output int cyc
  );
    cyc = 0;
    while (busy && cyc < 40) begin
      if (want_stall)
        chk("stall_busy", {31'd0, stall_md}, 32'd1);
      cyc++;
      step();
    end
    if (cyc >= 40)
      chk("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(
    input logic [2:0]  o,
    input logic [31:0] a,
    input logic [31:0] b
  );
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    step();
    start  = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    op       = '0;
    rs_val   = '0;
    rt_val   = '0;
    flush    = 1'b0;
    md_use_D = 1'b0;
    step();
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;
    step();

    // 1: MULT -3 * 5
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    chk("mult_busy0", {31'd0, busy}, 32'd1);
    wait_idle(1'b0, n);
    chk("mult_cyc", n, 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);

    // 2: DIVU, DIV, overflow divide
    issue(3'd3, 32'd7, 32'd2);
    wait_idle(1'b0, n);
    chk("divu_cyc", n, 32'd10);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(1'b0, n);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(1'b0, n);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'd0);

    // 3: MTHI/MTLO, then divide by zero
    issue(3'd4, 32'h0000_1234, 32'd0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", hi, 32'h0000_1234);
    issue(3'd5, 32'h0000_0055, 32'd0);
    chk("mtlo_lo", lo, 32'h0000_0055);
    chk("mtlo_hi", hi, 32'h0000_1234);
    issue(3'd2, 32'd5, 32'd0);
    wait_idle(1'b0, n);
    chk("dz_cyc", n, 32'd10);
    chk("dz_hi", hi, 32'h0000_1234);
    chk("dz_lo", lo, 32'h0000_0055);

    // 4: MULTU with D-stage md instruction
    md_use_D = 1'b1;
    start    = 1'b1;
    op       = 3'd1;
    rs_val   = 32'hFFFF_FFFF;
    rt_val   = 32'hFFFF_FFFF;
    #1;
    chk("stall_start", {31'd0, stall_md}, 32'd1);
    step();
    start = 1'b0;
    wait_idle(1'b1, n);
    chk("multu_cyc", n, 32'd5);
    chk("stall_drop", {31'd0, stall_md}, 32'd0);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'd1);
    md_use_D = 1'b0;

    // 5: async reset in the middle of a DIV
    issue(3'd2, 32'd100, 32'd7);
    step();
    step();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #2;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_hi", hi, 32'd0);
    chk("mid_rst_lo", lo, 32'd0);
    reset = 1'b1;
    step();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_lo", lo, 32'd0);
    issue(3'd0, 32'd2, 32'd3);
    wait_idle(1'b0, n);
    chk("rst_mult_lo", lo, 32'd6);
    chk("rst_mult_hi", hi, 32'd0);

    // 6: flushed start, ignored ops, start while busy
    md_use_D = 1'b1;
    flush    = 1'b1;
    start    = 1'b1;
    op       = 3'd0;
    rs_val   = 32'd9;
    rt_val   = 32'd9;
    #1;
    chk("flush_stall", {31'd0, stall_md}, 32'd0);
    step();
    start    = 1'b0;
    flush    = 1'b0;
    md_use_D = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_lo", lo, 32'd6);
    chk("flush_hi", hi, 32'd0);
    issue(3'd7, 32'hDEAD_BEEF, 32'd1);
    chk("op7_busy", {31'd0, busy}, 32'd0);
    chk("op7_lo", lo, 32'd6);
    issue(3'd6, 32'hDEAD_BEEF, 32'd1);
    chk("op6_hi", hi, 32'd0);

    issue(3'd0, 32'd3, 32'd4);
    issue(3'd5, 32'hDEAD_BEEF, 32'd0);
    chk("ign_busy", {31'd0, busy}, 32'd1);
    chk("ign_lo", lo, 32'd6);
    wait_idle(1'b0, n);
    chk("ign_cyc", n + 1, 32'd5);
    chk("ign_res_lo", lo, 32'd12);
    chk("ign_res_hi", hi, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
